// File: rtl/dcache_port_arbiter_pkg.sv
// Shared definitions for the data-cache port arbiter: FSM state encoding,
// requester identifiers and the request-qualification helper.
package dcache_port_arbiter_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic REQ_LSU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    // A requester is asking for the port when it has an access type and a qualified address.
    function automatic logic req_active(input logic rd, input logic wr, input logic addr_valid);
        return (rd | wr) & addr_valid;
    endfunction

endpackage

// File: rtl/dcache_port_arbiter_if.sv
// One cache-port bundle: the request side plus the completion/read-data return.
// The master drives the request; the slave answers with mem_done and rdata.
// On the cache side, rdata carries the DCache_data bus.
interface dcache_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              read_mem;
    logic              write_mem;
    logic [ADDR_W-1:0] addr;
    logic              addr_valid;
    logic [DATA_W-1:0] write_data;
    logic              write_data_valid;
    logic              mem_done;
    logic [DATA_W-1:0] rdata;

    modport master (
        output read_mem, write_mem, addr, addr_valid, write_data, write_data_valid,
        input  mem_done, rdata
    );

    modport slave (
        input  read_mem, write_mem, addr, addr_valid, write_data, write_data_valid,
        output mem_done, rdata
    );
endinterface

// File: rtl/dcache_port_arbiter_starve_ctr.sv
// Saturating count of consecutive LSU grants taken while DMA was waiting.
// force_dma tells the arbiter that DMA must win the next contested grant.
module arb_starve_ctr #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic lsu_grant,
    input  logic dma_grant,
    input  logic req_dma,
    output logic force_dma
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] cnt_p1;

    // Count LSU wins over a waiting DMA; any DMA win or uncontested grant restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p1 <= '0;
        end else if (dma_grant || (lsu_grant && !req_dma)) begin
            cnt_p1 <= '0;
        end else if (lsu_grant && (cnt_p1 < LIMIT)) begin
            cnt_p1 <= cnt_p1 + 4'd1;
        end
    end

    assign force_dma = (cnt_p1 == LIMIT);
endmodule

// File: rtl/dcache_port_arbiter.sv
// Two-master arbiter in front of the single data-cache request port.
// The winning request is registered and held toward the cache until mem_done;
// completion and load data are steered back to the owning requester only.
module dcache_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    dcache_port_arbiter_if.slave   lsu,
    dcache_port_arbiter_if.slave   dma,
    dcache_port_arbiter_if.master  cache,
    output logic                   owner,
    output logic                   busy
);
    import dcache_port_arbiter_pkg::*;

    logic [0:0]        state_p1;
    logic              owner_p1;
    logic              read_p1;
    logic              write_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic              addr_valid_p1;
    logic [DATA_W-1:0] wdata_p1;
    logic              wdv_p1;
    logic              wdv_seen_p1;

    logic              req_lsu;
    logic              req_dma;
    logic              force_dma;
    logic              grant;
    logic              win_dma;
    logic              win_rd;
    logic              win_wr;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              win_wdv;
    logic [DATA_W-1:0] own_wdata;
    logic              own_wdv;

    // Request qualification, winner selection and the winner/owner field muxes.
    always_comb begin
        req_lsu   = req_active(lsu.read_mem, lsu.write_mem, lsu.addr_valid);
        req_dma   = req_active(dma.read_mem, dma.write_mem, dma.addr_valid);
        grant     = (state_p1 == ST_IDLE) && (req_lsu || req_dma);
        // LSU has priority unless it has starved DMA for STARVE_LIMIT grants.
        win_dma   = req_dma && (!req_lsu || force_dma);
        win_rd    = win_dma ? dma.read_mem         : lsu.read_mem;
        win_wr    = win_dma ? dma.write_mem        : lsu.write_mem;
        win_addr  = win_dma ? dma.addr             : lsu.addr;
        win_wdata = win_dma ? dma.write_data       : lsu.write_data;
        win_wdv   = win_dma ? dma.write_data_valid : lsu.write_data_valid;
        own_wdata = (owner_p1 == REQ_DMA) ? dma.write_data       : lsu.write_data;
        own_wdv   = (owner_p1 == REQ_DMA) ? dma.write_data_valid : lsu.write_data_valid;
    end

    arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .lsu_grant (grant && !win_dma),
        .dma_grant (grant && win_dma),
        .req_dma   (req_dma),
        .force_dma (force_dma)
    );

    // Grant stage: latch the winner, hold it while busy, release on mem_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p1      <= ST_IDLE;
            owner_p1      <= REQ_LSU;
            read_p1       <= 1'b0;
            write_p1      <= 1'b0;
            addr_p1       <= '0;
            addr_valid_p1 <= 1'b0;
            wdata_p1      <= '0;
            wdv_p1        <= 1'b0;
            wdv_seen_p1   <= 1'b0;
        end else if (state_p1 == ST_IDLE) begin
            if (grant) begin
                state_p1      <= ST_BUSY;
                owner_p1      <= win_dma;
                // A simultaneous read+write is forwarded as a write only.
                read_p1       <= win_rd && !win_wr;
                write_p1      <= win_wr;
                addr_p1       <= win_addr;
                addr_valid_p1 <= 1'b1;
                wdata_p1      <= win_wdata;
                wdv_p1        <= win_wdv;
                wdv_seen_p1   <= win_wdv;
            end
        end else if (cache.mem_done) begin
            state_p1      <= ST_IDLE;
            read_p1       <= 1'b0;
            write_p1      <= 1'b0;
            addr_p1       <= '0;
            addr_valid_p1 <= 1'b0;
            wdata_p1      <= '0;
            wdv_p1        <= 1'b0;
            wdv_seen_p1   <= 1'b0;
        end else if (!wdv_seen_p1) begin
            // Store data may arrive after the address; follow it until it is valid once.
            wdata_p1    <= own_wdata;
            wdv_p1      <= own_wdv;
            wdv_seen_p1 <= own_wdv;
        end
    end

    assign busy  = (state_p1 == ST_BUSY);
    assign owner = owner_p1;

    assign cache.read_mem         = read_p1;
    assign cache.write_mem        = write_p1;
    assign cache.addr             = addr_p1;
    assign cache.addr_valid       = addr_valid_p1;
    assign cache.write_data       = wdata_p1;
    assign cache.write_data_valid = wdv_p1;

    // Completion is combinational from the cache and only reaches the current owner.
    assign lsu.mem_done = busy && (owner_p1 == REQ_LSU) && cache.mem_done;
    assign dma.mem_done = busy && (owner_p1 == REQ_DMA) && cache.mem_done;
    assign lsu.rdata    = lsu.mem_done ? cache.rdata : '0;
    assign dma.rdata    = dma.mem_done ? cache.rdata : '0;
endmodule

// File: doc/dcache_port_arbiter.md
Name: dcache_port_arbiter

Overview:
- Shares the single DCache_Controller request port between two masters: the core LSU (requester 0) and the CDMA engine (requester 1).
- Registers the winning request and holds it stable toward the cache until `mem_done`, then routes completion and read data back to the owner only.
- Sits between the Core/CDMA and the DCache_Controller; the cache-side signal set and semantics are unchanged.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, consecutive LSU grants allowed while DMA waits before DMA is forced to win; range 1..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- lsu_read_mem  in  1  LSU read request
- lsu_write_mem  in  1  LSU write request
- lsu_addr  in  ADDR_W  LSU address
- lsu_addr_valid  in  1  LSU address qualifier
- lsu_write_data  in  DATA_W  LSU store data
- lsu_write_data_valid  in  1  LSU store-data qualifier
- lsu_mem_done  out  1  LSU completion pulse
- lsu_rdata  out  DATA_W  LSU load data, valid with lsu_mem_done
- dma_read_mem, dma_write_mem, dma_addr, dma_addr_valid, dma_write_data, dma_write_data_valid  in  same widths as LSU  DMA request
- dma_mem_done  out  1  DMA completion pulse
- dma_rdata  out  DATA_W  DMA load data
- read_mem, write_mem  out  1  to cache
- addr  out  ADDR_W  to cache
- addr_valid  out  1  to cache
- write_data  out  DATA_W  to cache
- write_data_valid  out  1  to cache
- mem_done  in  1  cache completion pulse, one cycle
- DCache_data  in  DATA_W  cache read data, valid with mem_done
- owner  out  1  0 = LSU, 1 = DMA; meaningful only while busy
- busy  out  1  a transaction is outstanding

Behaviour:
- Reset value of every output is 0. State = IDLE, starve_cnt = 0, owner = 0.
- Request definition: req_x = (x_read_mem | x_write_mem) & x_addr_valid.
- If read and write are both set on one requester, write wins. The forwarded read_mem is 0 in that case.
- State IDLE:
  - No request: stay IDLE.
  - Only one request: grant it.
  - Both request: LSU wins unless starve_cnt == STARVE_LIMIT, in which case DMA wins.
- On grant, at the clock edge:
  - Latch rw, addr, write_data and write_data_valid of the winner into output registers.
  - Set busy = 1 and owner = winner.
  - Go to state BUSY.
  - Cache-side outputs are asserted the cycle after the request was first seen (1-cycle grant latency).
- starve_cnt:
  - Increments on an LSU grant while req_dma = 1.
  - Clears on any DMA grant, or on any grant while req_dma = 0.
  - Saturates at STARVE_LIMIT.
- State BUSY:
  - Cache-side outputs are held constant, except write_data / write_data_valid. These track the owner's live values until write_data_valid has been seen high once; after that they are frozen.
  - Requester inputs are otherwise ignored; the non-owner simply waits.
- mem_done in BUSY:
  - Combinationally drives owner's x_mem_done = 1 and x_rdata = DCache_data in the same cycle.
  - The non-owner's done output stays 0 and its rdata stays 0.
  - At the next edge: go to IDLE, clear all cache-side outputs and busy.
  - The requester must drop its request in the cycle after its done pulse. A request still present in IDLE is treated as a new transaction.
- mem_done while IDLE: ignored, no done pulse to either requester.
- Back-to-back transactions: the minimum gap is one IDLE cycle between done and the next cache-side request.
- Reset asserted mid-transaction: all outputs clear immediately (asynchronously). The outstanding transaction is dropped and no done pulse is generated.
- No combinational path from requester inputs to cache-side outputs.

Decomposition:
- Shared package holds:
  - state encoding: IDLE = 1'b0, BUSY = 1'b1;
  - requester IDs: REQ_LSU = 0, REQ_DMA = 1.
- One sub-module, `arb_starve_ctr`: the saturating starvation counter with its force-DMA output. Everything else is in the top level.

Test Plan:
- LSU alone, read, addr = 0x100 at cycle 0; mem_done at cycle 4 with DCache_data = 0xDEADBEEF → read_mem = 1 and addr = 0x100 from cycle 1; lsu_mem_done = 1 and lsu_rdata = 0xDEADBEEF at cycle 4; dma_mem_done = 0; busy = 0 at cycle 5.
- DMA write (addr = 0x200, data = 0x55) while LSU idle → write_mem = 1, write_data = 0x55, owner = 1; done returns only on dma_mem_done.
- Both request continuously, STARVE_LIMIT = 4, each transaction completes in 2 cycles → grant order LSU, LSU, LSU, LSU, DMA, then repeats.
- DMA requests while an LSU transaction is BUSY → cache-side addr unchanged until mem_done; DMA is granted in the first IDLE cycle after LSU's done.
- Spurious mem_done in IDLE → no done pulse, outputs stay 0; rst_n pulled low during BUSY → all outputs 0 immediately and state IDLE after release.
